// File: rtl/mem_pkg.sv
// Shared types and constants for the array minimum scan engine.
// Holds the FSM encoding, word stride and the empty-scan sentinel.
package mem_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [31:0] MIN_INIT = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/signed_min_cmp.sv
// Signed "is the candidate a new minimum" decision.
// Strict less-than, so ties keep the earlier element.
module signed_min_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] cand,
  input  logic         first,
  output logic         take_new
);

  assign take_new = first | ($signed(cand) < $signed(cur));

endmodule

// File: rtl/min_scan_engine.sv
// Bus master that scans a signed word array for its minimum
// and writes the result back to a destination word address.
module min_scan_engine
  import mem_pkg::*;
#(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  base_adr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADR_W-1:0]  dst_adr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] min_val,
  output logic [CNT_W-1:0]  min_idx,
  output logic [ADR_W-1:0]  mem_adr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [DATA_W-1:0] INIT =
    {1'b0, {(DATA_W-1){1'b1}}};

  state_t             state;
  logic [ADR_W-1:0]   ptr;
  logic [ADR_W-1:0]   dst_q;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt_q;
  logic               take_new;
  logic               last;

  signed_min_cmp #(
    .W (DATA_W)
  ) u_cmp (
    .cur      (min_val),
    .cand     (mem_rdata),
    .first    (idx == '0),
    .take_new (take_new)
  );

  assign last = (idx == cnt_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      dst_q   <= '0;
      idx     <= '0;
      cnt_q   <= '0;
      min_val <= '0;
      min_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt_q <= count;
            dst_q <= dst_adr;
            ptr   <= base_adr;
            idx   <= '0;
            if (count != '0) begin
              state <= READ;
            end else begin
              // empty array: report the sentinel, touch no memory
              min_val <= INIT;
              min_idx <= '0;
              state   <= DONE;
            end
          end
        end
        READ: begin
          if (take_new) begin
            min_val <= mem_rdata;
            min_idx <= idx;
          end
          ptr <= ptr + ADR_W'(WORD_BYTES);
          idx <= idx + CNT_W'(1);
          if (last) state <= WRITE;
        end
        WRITE: state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode from state so reset drops them at once
  always_comb begin
    mem_adr   = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      READ: begin
        mem_adr = ptr;
        mem_rd  = 1'b1;
      end
      WRITE: begin
        mem_adr   = dst_q;
        mem_wr    = 1'b1;
        mem_wdata = min_val;
      end
      default: ;
    endcase
  end

  assign busy = (state == READ) || (state == WRITE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_min_scan_engine.sv
// Directed bench for min_scan_engine with a small word memory.
// Checks bus timing, results, writeback and async reset abort.
module tb_min_scan_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] count = '0;
  logic [31:0] dst_adr = '0;
  logic        busy;
  logic        done;
  logic [31:0] min_val;
  logic [15:0] min_idx;
  logic [31:0] mem_adr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];
  int checks = 0;
  int errors = 0;
  int wr_total = 0;

  min_scan_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .count     (count),
    .dst_adr   (dst_adr),
    .busy      (busy),
    .done      (done),
    .min_val   (min_val),
    .min_idx   (min_idx),
    .mem_adr   (mem_adr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_adr[11:2]];

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_adr[11:2]] <= mem_wdata;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [31:0] b,
                          input logic [15:0] n,
                          input logic [31:0] d,
                          input logic [31:0] emin,
                          input logic [15:0] eidx,
                          input bit repulse);
    int w0;
    int lastc;
    bit rd_e, wr_e, dn_e;
    @(negedge clk);
    base_adr = b;
    count = n;
    dst_adr = d;
    start = 1'b1;
    w0 = wr_total;
    @(posedge clk);
    #1 start = 1'b0;
    lastc = (n == 0) ? 1 : int'(n) + 2;
    for (int c = 1; c <= lastc + 2; c++) begin
      @(negedge clk);
      if (repulse && c == 2) begin
        start = 1'b1;
        base_adr = b + 32'd4;
        count = 16'd1;
        dst_adr = d + 32'd4;
      end
      if (repulse && c == 3) start = 1'b0;
      rd_e = (n != 0) && (c <= int'(n));
      wr_e = (n != 0) && (c == int'(n) + 1);
      dn_e = (c == lastc);
      chk("mem_rd", {31'b0, mem_rd}, {31'b0, rd_e});
      chk("mem_wr", {31'b0, mem_wr}, {31'b0, wr_e});
      chk("busy", {31'b0, busy}, {31'b0, rd_e | wr_e});
      chk("done", {31'b0, done}, {31'b0, dn_e});
      if (rd_e)
        chk("rd_adr", mem_adr, b + 32'(4 * (c - 1)));
      if (wr_e) begin
        chk("wr_adr", mem_adr, d);
        chk("wdata", mem_wdata, emin);
      end
      if (!rd_e && !wr_e)
        chk("idle_adr", mem_adr, 32'd0);
    end
    chk("min_val", min_val, emin);
    chk("min_idx", {16'b0, min_idx}, {16'b0, eidx});
    chk("writes", 32'(wr_total - w0), (n != 0) ? 32'd1 : 32'd0);
    if (n != 0) chk("ram_dst", ram[d[11:2]], emin);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[250] = 32'd5;
    ram[251] = 32'hFFFF_FFFD;
    ram[252] = 32'd7;
    ram[253] = 32'hFFFF_FFFD;
    ram[254] = 32'd2;
    ram[275] = 32'h8000_0000;
    for (int i = 300; i < 304; i++) ram[i] = 32'd7;
    ram[325] = 32'h7FFF_FFFF;
    ram[326] = 32'h0000_0000;
    ram[327] = 32'h8000_0000;
    ram[502] = 32'hDEAD_BEEF;

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_adr", mem_adr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_min", min_val, 32'd0);
    chk("rst_idx", {16'b0, min_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_scan(32'd1000, 16'd5, 32'd2000, 32'hFFFF_FFFD, 16'd1, 1'b0);
    run_scan(32'd1100, 16'd1, 32'd2004, 32'h8000_0000, 16'd0, 1'b0);
    run_scan(32'd1000, 16'd0, 32'd2020, 32'h7FFF_FFFF, 16'd0, 1'b0);
    chk("cnt0_ram", ram[505], 32'd0);
    run_scan(32'd1200, 16'd4, 32'd2012, 32'd7, 16'd0, 1'b0);
    run_scan(32'd1300, 16'd3, 32'd2016, 32'h8000_0000, 16'd2, 1'b0);
    run_scan(32'd1000, 16'd5, 32'd2024, 32'hFFFF_FFFD, 16'd1, 1'b1);
    chk("repulse_ram", ram[507], 32'd0);
    run_scan(32'd1200, 16'd4, 32'd2028, 32'd7, 16'd0, 1'b0);

    @(negedge clk);
    base_adr = 32'd1000;
    count = 16'd5;
    dst_adr = 32'd2008;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_rd", {31'b0, mem_rd}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rd", {31'b0, mem_rd}, 32'd0);
    chk("abort_wr", {31'b0, mem_wr}, 32'd0);
    chk("abort_adr", mem_adr, 32'd0);
    chk("abort_min", min_val, 32'd0);
    chk("abort_idx", {16'b0, min_idx}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_ram", ram[502], 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_done", {31'b0, done}, 32'd0);
    run_scan(32'd1000, 16'd5, 32'd2008, 32'hFFFF_FFFD, 16'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
